// File: rtl/ex_stage_pipe_reg_if.sv
// Valid/ready bus carrying one control bundle and one data bundle between
// two pipeline stages.
interface ex_stage_pipe_reg_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 112
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/ex_stage_pipe_reg.sv
// Elastic EX-stage register: main entry plus one skid entry, registered
// in_ready, bubble-masked control, flush squash and a saturating stall counter.
module ex_stage_pipe_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 112,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    ex_stage_pipe_reg_if.slave  inBus,
    ex_stage_pipe_reg_if.master outBus,
    output logic [CNT_W-1:0]    stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    occ_t              occ;
    logic              inReady_p0;
    logic              mainVld_p1;
    logic [CTRL_W-1:0] mainCtrl_p1;
    logic [DATA_W-1:0] mainData_p1;
    logic              skidVld_p0;
    logic [CTRL_W-1:0] skidCtrl_p0;
    logic [DATA_W-1:0] skidData_p0;
    logic [CNT_W-1:0]  stallCnt_p1;

    logic accIn;
    logic accOut;
    logic stallNow;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt,
                                                input logic             en);
        if (en && (cnt != CNT_MAX)) begin
            return cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

    assign accIn    = inBus.valid & inReady_p0;
    assign accOut   = mainVld_p1 & outBus.ready;
    assign stallNow = mainVld_p1 & ~outBus.ready;

    // Control registers are zeroed whenever their slot empties, so an empty
    // slot can never assert RegWrite/MemWr/Branch downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ         <= EMPTY;
            inReady_p0  <= 1'b1;
            mainVld_p1  <= 1'b0;
            mainCtrl_p1 <= '0;
            mainData_p1 <= '0;
            skidVld_p0  <= 1'b0;
            skidCtrl_p0 <= '0;
            skidData_p0 <= '0;
            stallCnt_p1 <= '0;
        end else begin
            stallCnt_p1 <= satInc(stallCnt_p1, stallNow);
            if (flush) begin
                occ         <= EMPTY;
                inReady_p0  <= 1'b1;
                mainVld_p1  <= 1'b0;
                mainCtrl_p1 <= '0;
                skidVld_p0  <= 1'b0;
                skidCtrl_p0 <= '0;
            end else begin
                case (occ)
                    EMPTY: begin
                        if (accIn) begin
                            mainVld_p1  <= 1'b1;
                            mainCtrl_p1 <= inBus.ctrl;
                            mainData_p1 <= inBus.data;
                            occ         <= ONE;
                        end
                    end
                    ONE: begin
                        if (accOut && accIn) begin
                            mainCtrl_p1 <= inBus.ctrl;
                            mainData_p1 <= inBus.data;
                        end else if (accOut) begin
                            mainVld_p1  <= 1'b0;
                            mainCtrl_p1 <= '0;
                            occ         <= EMPTY;
                        end else if (accIn) begin
                            skidVld_p0  <= 1'b1;
                            skidCtrl_p0 <= inBus.ctrl;
                            skidData_p0 <= inBus.data;
                            inReady_p0  <= 1'b0;
                            occ         <= FULL;
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so the skid entry is the only source.
                        if (accOut) begin
                            mainCtrl_p1 <= skidCtrl_p0;
                            mainData_p1 <= skidData_p0;
                            skidVld_p0  <= 1'b0;
                            skidCtrl_p0 <= '0;
                            inReady_p0  <= 1'b1;
                            occ         <= ONE;
                        end
                    end
                    default: begin
                        occ         <= EMPTY;
                        inReady_p0  <= 1'b1;
                        mainVld_p1  <= 1'b0;
                        mainCtrl_p1 <= '0;
                        skidVld_p0  <= 1'b0;
                        skidCtrl_p0 <= '0;
                    end
                endcase
            end
        end
    end

    assign inBus.ready  = inReady_p0;
    assign outBus.valid = mainVld_p1;
    assign outBus.ctrl  = mainCtrl_p1;
    assign outBus.data  = mainData_p1;
    assign stall_cnt    = stallCnt_p1;

endmodule

// File: doc/ex_stage_pipe_reg.md
# ex_stage_pipe_reg

Parametrised, elastic pipeline stage register for the 5-stage datapath, the generalised replacement for the fixed ID/EX register. Carries a CTRL_W-bit control bundle and a DATA_W-bit data bundle between two stages under a valid/ready handshake, with a two-entry skid buffer so `in_ready` is driven directly from a register. Control bits are zeroed whenever the slot is invalid, so an empty slot is a bubble. A synchronous flush squashes the stage on a branch/jump, and a saturating counter records back-pressure cycles for the hazard unit and for debug.

## Interface
- CTRL_W, 16: control bundle width (RegDst, ALUSrc, MemToReg, RegWrite, MemWr, Branch, Jump, AluCtrl, Dsize, …); zeroed on bubble.
- DATA_W, 112: data bundle width (Imm16, BusA, BusB, rt/rd, PC+4); held, not zeroed, on bubble.
- CNT_W, 16: stall-counter width; minimum 1.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash both entries this edge.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept; registered, equal to !skid_valid.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  main control; forced 0 when out_valid=0.
- out_data  out  DATA_W  main data.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage: a main entry (m_v, m_c, m_d) drives the outputs; a skid entry (s_v, s_c, s_d) is used only under back-pressure.
- acc_in = in_valid & in_ready; acc_out = m_v & out_ready.
- Occupancy states:
  - EMPTY: m_v=0, s_v=0.
  - ONE: m_v=1, s_v=0.
  - FULL: m_v=1, s_v=1; in_ready=0.
- Per edge, with reset=0 and flush=0:
  - Main free (!m_v or acc_out) and s_v: main loads skid, s_v cleared. acc_in is impossible in this case.
  - Main free and !s_v: main loads the input if acc_in; otherwise m_v clears.
  - Main held (m_v & !out_ready): an accepted input goes to skid, s_v set.
- Transitions:
  - EMPTY→ONE on acc_in.
  - ONE→ONE on acc_in&acc_out, or on neither.
  - ONE→EMPTY on acc_out only.
  - ONE→FULL on acc_in without acc_out.
  - FULL→ONE on acc_out.
  - FULL holds otherwise.
- Entries leave in arrival order. No entry is ever dropped or duplicated except by flush or reset.
- Bubble rule: when m_v=0, out_ctrl=0 (masked register or registered zero), so RegWrite/MemWr/Branch are never asserted by an empty slot. out_data keeps its last value.
- Flush: m_v, s_v, m_c and s_c are cleared at the edge. Any input offered in the same cycle is discarded, even if in_ready=1. Data registers are not cleared. stall_cnt is unaffected.
- stall_cnt increments when m_v & !out_ready and saturates at 2^CNT_W−1. It is cleared only by reset.
- Priority: reset > flush > normal transfer.

## Timing
- Reset values, visible after the reset edge:
  - out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0.
  - Inputs are ignored while reset=1.
  - Reset asserted mid-operation discards both entries at that edge.
- Latency: an input accepted at edge N appears on out_* after edge N (one cycle) when the stage was EMPTY or draining.
- Throughput: one entry per cycle with out_ready held high; in_ready stays 1.
- in_ready has no combinational path from out_ready or in_valid. It drops the cycle after the stage enters FULL and rises the cycle after a FULL-state acc_out.
- out_ctrl, out_valid and out_data have no combinational input paths.
- Flush cycle: out_valid=0 and out_ctrl=0 after that edge; in_ready=1 after that edge.

## Test plan
- Stream: reset, then in_valid=1, out_ready=1, in_ctrl=1..8 over 8 cycles → out_ctrl=1..8 one cycle later each, in_ready always 1, stall_cnt=0.
- Back-pressure: send A then B, out_ready=0 for 3 cycles →
  - FULL reached and in_ready=0 while FULL.
  - stall_cnt=3.
  - After out_ready=1, A then B on consecutive cycles; C offered meanwhile is not accepted until in_ready=1.
- Bubble: in_valid=0 with in_ctrl=16'hFFFF → out_valid=0 and out_ctrl=0 every cycle.
- Flush in FULL with in_valid=1 (entry D) → after the edge, out_valid=0, out_ctrl=0, in_ready=1; D never appears at the output.
- Saturation: CNT_W=2, out_valid held high with out_ready=0 for 6 cycles → stall_cnt reads 1,2,3,3,3,3.
- Reset mid-transfer while FULL → all outputs at reset values next cycle; the first post-reset input has 1-cycle latency.
